// File: rtl/spi_slave_axi_mem_if.sv
// AXI4 bundle between the SPI-slave AXI plug (master) and the standalone
// responder memory (slave).
interface spi_slave_axi_mem_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3
);
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_region;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [3:0]                  aw_qos;
  logic [AXI_USER_WIDTH-1:0]   aw_user;

  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;

  logic                        b_valid;
  logic                        b_ready;
  logic [1:0]                  b_resp;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [AXI_USER_WIDTH-1:0]   b_user;

  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_region;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [3:0]                  ar_qos;
  logic [AXI_USER_WIDTH-1:0]   ar_user;

  logic                        r_valid;
  logic                        r_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_id, aw_size, aw_burst, aw_prot,
           aw_region, aw_lock, aw_cache, aw_qos, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp, b_id, b_user,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_id, ar_size, ar_burst, ar_prot,
           ar_region, ar_lock, ar_cache, ar_qos, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_id, aw_size, aw_burst, aw_prot,
           aw_region, aw_lock, aw_cache, aw_qos, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp, b_id, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_id, ar_size, ar_burst, ar_prot,
           ar_region, ar_lock, ar_cache, ar_qos, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, r_user,
    input  r_ready
  );
endinterface

// File: rtl/spi_slave_axi_mem.sv
// Standalone AXI4 responder RAM for the SPI-slave AXI plug: single-beat
// reads/writes, multi-beat bursts drained and answered with SLVERR.
module spi_slave_axi_mem #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AXI_ID_WIDTH   = 3,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic                axi_aclk,
  input logic                axi_aresetn,
  spi_slave_axi_mem_if.slave axi_slave
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [1:0] resp_code(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                           input logic [7:0]                len);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (len != 8'd0)
      return RESP_SLVERR;
    // Any offset bit above the word index means the access runs past the RAM.
    if ((addr < BASE_ADDR) || ((off >> (OFFS_W + IDX_W)) != '0))
      return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> OFFS_W);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------- write channel ----------------
  w_state_e                w_state;
  logic [IDX_W-1:0]        w_idx_q;
  logic [7:0]              w_len_q;
  logic [7:0]              w_cnt_q;
  logic                    aw_ready_q;
  logic                    w_ready_q;
  logic                    b_valid_q;
  logic [1:0]              b_resp_q;
  logic [AXI_ID_WIDTH-1:0] b_id_q;
  logic                    w_beat;
  logic                    mem_we;

  assign w_beat = w_ready_q && axi_slave.w_valid;
  assign mem_we = w_beat && (b_resp_q == RESP_OKAY);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state    <= W_IDLE;
      w_idx_q    <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
      b_id_q     <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (axi_slave.aw_valid && aw_ready_q) begin
            w_idx_q    <= word_idx(axi_slave.aw_addr);
            w_len_q    <= axi_slave.aw_len;
            w_cnt_q    <= '0;
            b_id_q     <= axi_slave.aw_id;
            b_resp_q   <= resp_code(axi_slave.aw_addr, axi_slave.aw_len);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            // A burst ends on w_last or once len+1 beats are in, whichever is first.
            if (axi_slave.w_last || (w_cnt_q == w_len_q)) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              w_state   <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi_slave.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: begin
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_state    <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (axi_slave.w_strb[i])
          mem[w_idx_q][8*i +: 8] <= axi_slave.w_data[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e                  r_state;
  logic                      ar_ready_q;
  logic                      r_valid_q;
  logic                      r_last_q;
  logic [7:0]                r_len_q;
  logic [7:0]                r_cnt_q;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [1:0]                r_resp_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]                ar_code;

  assign ar_code = resp_code(axi_slave.ar_addr, axi_slave.ar_len);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_id_q     <= '0;
      r_resp_q   <= '0;
      r_data_q   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (axi_slave.ar_valid && ar_ready_q) begin
            r_id_q     <= axi_slave.ar_id;
            r_len_q    <= axi_slave.ar_len;
            r_resp_q   <= ar_code;
            r_cnt_q    <= '0;
            r_last_q   <= (axi_slave.ar_len == 8'd0);
            // Sampled before any same-cycle write lands, so the old word is returned.
            r_data_q   <= (ar_code == RESP_OKAY) ? mem[word_idx(axi_slave.ar_addr)] : '0;
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            r_state    <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_slave.r_ready) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state    <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
              r_data_q <= '0;
            end
          end
        end
        default: begin
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
          ar_ready_q <= 1'b1;
          r_state    <= R_IDLE;
        end
      endcase
    end
  end

  assign axi_slave.aw_ready = aw_ready_q;
  assign axi_slave.w_ready  = w_ready_q;
  assign axi_slave.b_valid  = b_valid_q;
  assign axi_slave.b_resp   = b_resp_q;
  assign axi_slave.b_id     = b_id_q;
  assign axi_slave.b_user   = '0;
  assign axi_slave.ar_ready = ar_ready_q;
  assign axi_slave.r_valid  = r_valid_q;
  assign axi_slave.r_data   = r_data_q;
  assign axi_slave.r_resp   = r_resp_q;
  assign axi_slave.r_last   = r_last_q;
  assign axi_slave.r_id     = r_id_q;
  assign axi_slave.r_user   = '0;

  logic unused_sideband;
  assign unused_sideband = ^{axi_slave.aw_size, axi_slave.aw_burst, axi_slave.aw_prot,
                             axi_slave.aw_region, axi_slave.aw_lock, axi_slave.aw_cache,
                             axi_slave.aw_qos, axi_slave.aw_user, axi_slave.w_user,
                             axi_slave.ar_size, axi_slave.ar_burst, axi_slave.ar_prot,
                             axi_slave.ar_region, axi_slave.ar_lock, axi_slave.ar_cache,
                             axi_slave.ar_qos, axi_slave.ar_user};
endmodule
